// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory load/fetch sequencer:
// state encodings, default geometry and the filler opcode used on idle write cycles.
package imem_load_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } imem_state_e;

    localparam int          NUM_WORD_DEF = 16;
    localparam int          PREFETCH_DEF = 4;
    localparam logic [31:0] NOOP         = 32'hFC00_003F;

    function automatic logic pops_allowed(input imem_state_e s);
        return (s == ST_LOAD) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/imem_load_ctrl_fetch_pc.sv
// Fetch program counter: redirect beats stall/STOP, sequential advance never
// passes the write pointer, and out-of-range redirect targets are flagged.
module imem_fetch_pc
    import imem_load_ctrl_pkg::*;
#(
    parameter int NUM_WORD = NUM_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        stall_i,
    input  logic        mem_stop_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_addr_i,
    input  logic [31:0] wr_ptr_i,
    output logic [31:0] rd_addr_o,
    output logic        bad_redirect_o,
    output logic        advance_o
);

    localparam logic [31:0] NUM_WORD_U = 32'(NUM_WORD);

    logic [31:0] rd_addr_q, rd_addr_d;
    logic        bad_redirect_q, bad_redirect_d;
    logic [31:0] rd_addr_inc;

    assign rd_addr_inc = rd_addr_q + 32'd1;

    // An advance attempt is any fetch cycle not consumed by a redirect or a hold.
    assign advance_o = en_i & ~redirect_valid_i & ~stall_i & ~mem_stop_i;

    always_comb begin
        rd_addr_d      = rd_addr_q;
        bad_redirect_d = bad_redirect_q;
        if (en_i) begin
            if (redirect_valid_i) begin
                if (redirect_addr_i < NUM_WORD_U) begin
                    rd_addr_d = redirect_addr_i;
                end else begin
                    bad_redirect_d = 1'b1;
                end
            end else if (!(stall_i || mem_stop_i)) begin
                if (rd_addr_inc < wr_ptr_i) begin
                    rd_addr_d = rd_addr_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q      <= 32'd0;
            bad_redirect_q <= 1'b0;
        end else begin
            rd_addr_q      <= rd_addr_d;
            bad_redirect_q <= bad_redirect_d;
        end
    end

    assign rd_addr_o      = rd_addr_q;
    assign bad_redirect_o = bad_redirect_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Loads a 16-word instruction memory from a show-ahead FIFO and sequences
// its fetch side once enough words are resident.
//
//  state | meaning
//  IDLE  | waiting for the first FIFO word
//  LOAD  | popping/writing words, fetch not yet enabled
//  RUN   | fetch enabled, loading continues until memory is full
//  HALT  | fetch ran off the top of memory; left only by reset
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int NUM_WORD = NUM_WORD_DEF,
    parameter int PREFETCH = PREFETCH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_empty_i,
    input  logic [32:0] fifo_rdata_i,
    output logic        fifo_rd_en_o,
    output logic [31:0] wr_addr_o,
    output logic [32:0] wr_data_o,
    output logic [31:0] rd_addr_o,
    output logic        pc_start_o,
    input  logic        mem_stop_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_addr_i,
    output logic        load_done_o,
    output logic        bad_redirect_o,
    output logic [1:0]  state_o
);

    localparam logic [31:0] NUM_WORD_U = 32'(NUM_WORD);
    localparam logic [31:0] PREFETCH_U = 32'(PREFETCH);
    localparam logic [31:0] TOP_ADDR   = NUM_WORD_U - 32'd1;

    imem_state_e state_q, state_d;
    logic [31:0] wr_ptr_q, wr_ptr_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [32:0] wr_data_q, wr_data_d;
    logic        pc_start_q, pc_start_d;
    logic        load_done_q, load_done_d;

    logic        mem_full;
    logic        pop;
    logic        fetch_en;
    logic        fetch_advance;

    assign mem_full = (wr_ptr_q == NUM_WORD_U);
    assign pop      = pops_allowed(state_q) & ~fifo_empty_i & (wr_ptr_q < NUM_WORD_U);
    assign fetch_en = (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = {1'b0, NOOP};
        pc_start_d  = pc_start_q;
        load_done_d = load_done_q | mem_full;

        // Words with the valid bit clear are consumed but never written.
        if (pop && fifo_rdata_i[32]) begin
            wr_addr_d = wr_ptr_q;
            wr_data_d = fifo_rdata_i;
            wr_ptr_d  = wr_ptr_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if ((wr_ptr_q >= PREFETCH_U) || (fifo_empty_i && (wr_ptr_q != 32'd0))) begin
                    state_d    = ST_RUN;
                    pc_start_d = 1'b1;
                end
            end
            ST_RUN: begin
                if ((rd_addr_o == TOP_ADDR) && fetch_advance) begin
                    state_d    = ST_HALT;
                    pc_start_d = 1'b0;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= 32'd0;
            wr_addr_q   <= 32'd0;
            wr_data_q   <= 33'd0;
            pc_start_q  <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            pc_start_q  <= pc_start_d;
            load_done_q <= load_done_d;
        end
    end

    // Fetch sees the pre-pop write pointer, so a word written this cycle is
    // only fetchable from the next one.
    imem_fetch_pc #(
        .NUM_WORD (NUM_WORD)
    ) u_fetch_pc (
        .clk              (clk),
        .rst_n            (rst_n),
        .en_i             (fetch_en),
        .stall_i          (stall_i),
        .mem_stop_i       (mem_stop_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_addr_i  (redirect_addr_i),
        .wr_ptr_i         (wr_ptr_q),
        .rd_addr_o        (rd_addr_o),
        .bad_redirect_o   (bad_redirect_o),
        .advance_o        (fetch_advance)
    );

    assign fifo_rd_en_o = pop;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign pc_start_o   = pc_start_q;
    assign load_done_o  = load_done_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: a FIFO model feeds the DUT and a write scoreboard
// checks every memory write against the words queued at push time.
module tb_imem_load_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic [32:0] data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic [32:0] fifo_rdata;
    logic        fifo_rd_en;
    logic [31:0] wr_addr;
    logic [32:0] wr_data;
    logic [31:0] rd_addr;
    logic        pc_start;
    logic        mem_stop;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        load_done;
    logic        bad_redirect;
    logic [1:0]  state;

    logic [32:0] fifo_q[$];
    wr_exp_t     exp_wr[$];
    int          exp_ptr  = 0;
    int          n_vec    = 0;
    int          n_miss   = 0;
    int          n_pops   = 0;
    int          n_writes = 0;
    int          cyc      = 0;
    logic        pop_seen = 1'b0;

    always #5 clk = ~clk;

    imem_load_ctrl #(.NUM_WORD(16), .PREFETCH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fifo_empty_i     (fifo_empty),
        .fifo_rdata_i     (fifo_rdata),
        .fifo_rd_en_o     (fifo_rd_en),
        .wr_addr_o        (wr_addr),
        .wr_data_o        (wr_data),
        .rd_addr_o        (rd_addr),
        .pc_start_o       (pc_start),
        .mem_stop_i       (mem_stop),
        .stall_i          (stall),
        .redirect_valid_i (redirect_valid),
        .redirect_addr_i  (redirect_addr),
        .load_done_o      (load_done),
        .bad_redirect_o   (bad_redirect),
        .state_o          (state)
    );

    // Show-ahead FIFO model: the pop strobe is sampled mid-cycle, the head is retired after the edge.
    always @(negedge clk) pop_seen = fifo_rd_en;

    always @(posedge clk) begin
        logic [32:0] dropped;
        #1;
        cyc++;
        if (pop_seen && rst_n && fifo_q.size() > 0) begin
            dropped = fifo_q.pop_front();
            n_pops++;
        end
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 33'd0;
    end

    always @(negedge clk) begin
        wr_exp_t e;
        if (rst_n && wr_data[32]) begin
            n_writes++;
            n_vec++;
            if (exp_wr.size() == 0) begin
                n_miss++;
                $display("FAIL wr_unexpected got addr=%0d data=%h, required no write", wr_addr, wr_data);
            end else begin
                e = exp_wr.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    n_miss++;
                    $display("FAIL wr_scoreboard got addr=%0d data=%h, required addr=%0d data=%h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic valid, input logic [31:0] instr);
        wr_exp_t e;
        fifo_q.push_back({valid, instr});
        if (valid && exp_ptr < 16) begin
            e.addr = 32'(exp_ptr);
            e.data = {1'b1, instr};
            exp_wr.push_back(e);
            exp_ptr++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        stall          = 1'b0;
        mem_stop       = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'd0;
        fifo_q.delete();
        exp_wr.delete();
        exp_ptr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        fifo_empty     = 1'b1;
        fifo_rdata     = 33'd0;
        stall          = 1'b0;
        mem_stop       = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'd0;
        #1;
        n_vec++;
        if ({wr_addr, wr_data, rd_addr, pc_start, load_done, bad_redirect, state, fifo_rd_en} !== '0) begin
            n_miss++;
            $display("FAIL reset_outputs got wr_addr=%0d wr_data=%h rd_addr=%0d pc_start=%b load_done=%b bad=%b state=%0d rd_en=%b, required all 0",
                     wr_addr, wr_data, rd_addr, pc_start, load_done, bad_redirect, state, fifo_rd_en);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mid_reset();
        int base;
        do_reset();
        base = n_pops;
        for (int i = 0; i < 8; i++) push(1'b1, 32'h1000 + 32'(i));
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #2;
            if (n_pops - base >= 3) break;
        end
        n_vec++;
        if (n_pops - base != 3) begin
            n_miss++;
            $display("FAIL midrst_pops got %0d, required 3", n_pops - base);
        end
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({wr_addr, wr_data, rd_addr, pc_start, load_done, bad_redirect} !== '0 || state !== 2'd0) begin
            n_miss++;
            $display("FAIL midrst_outputs got wr_addr=%0d wr_data=%h rd_addr=%0d pc_start=%b state=%0d, required all 0",
                     wr_addr, wr_data, rd_addr, pc_start, state);
        end
        n_vec++;
        if (exp_wr.size() != 5) begin
            n_miss++;
            $display("FAIL midrst_writes got %0d pending, required 5", exp_wr.size());
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (fifo_rd_en !== 1'b0 || fifo_empty !== 1'b0) begin
                n_miss++;
                $display("FAIL midrst_rd_en got rd_en=%b fifo_empty=%b, required rd_en=0 with fifo non-empty",
                         fifo_rd_en, fifo_empty);
            end
        end
        fifo_q.delete();
        exp_wr.delete();
        exp_ptr = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_load_run();
        int   base, p4, ps;
        logic seq_ok;
        logic [31:0] prev_rd;
        do_reset();
        base = n_pops; p4 = -1; ps = -1; seq_ok = 1'b1; prev_rd = 32'd0;
        for (int i = 0; i < 6; i++) push(1'b1, 32'h0100 + 32'(i));
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            if (p4 < 0 && n_pops - base >= 4) p4 = cyc;
            if (ps < 0 && pc_start) ps = cyc;
            if (rd_addr != prev_rd && rd_addr != prev_rd + 32'd1) seq_ok = 1'b0;
            prev_rd = rd_addr;
        end
        n_vec++;
        if (p4 < 0 || ps != p4 + 1) begin
            n_miss++;
            $display("FAIL lr_pc_start_latency got pc_start cycle %0d, required %0d", ps, p4 + 1);
        end
        n_vec++;
        if (!seq_ok) begin
            n_miss++;
            $display("FAIL lr_rd_seq got non-sequential rd_addr, required steps of 0 or 1");
        end
        n_vec++;
        if (rd_addr !== 32'd5 || state !== 2'd2 || pc_start !== 1'b1) begin
            n_miss++;
            $display("FAIL lr_final got rd_addr=%0d state=%0d pc_start=%b, required 5 2 1", rd_addr, state, pc_start);
        end
        n_vec++;
        if (exp_wr.size() != 0 || n_pops - base != 6) begin
            n_miss++;
            $display("FAIL lr_drain got pending=%0d pops=%0d, required 0 6", exp_wr.size(), n_pops - base);
        end
    endtask

    task automatic test_short();
        do_reset();
        push(1'b1, 32'h2000);
        push(1'b1, 32'h2001);
        repeat (20) @(posedge clk);
        #2;
        n_vec++;
        if (state !== 2'd2 || rd_addr !== 32'd1 || pc_start !== 1'b1 || load_done !== 1'b0) begin
            n_miss++;
            $display("FAIL short_prog got state=%0d rd_addr=%0d pc_start=%b load_done=%b, required 2 1 1 0",
                     state, rd_addr, pc_start, load_done);
        end
        n_vec++;
        if (exp_wr.size() != 0) begin
            n_miss++;
            $display("FAIL short_drain got %0d pending, required 0", exp_wr.size());
        end
    endtask

    task automatic test_invalid();
        int base_w;
        do_reset();
        base_w = n_writes;
        push(1'b1, 32'h0000_000A);
        push(1'b0, 32'h0000_DEAD);
        push(1'b1, 32'h0000_000B);
        repeat (20) @(posedge clk);
        #2;
        n_vec++;
        if (n_writes - base_w != 2 || exp_wr.size() != 0) begin
            n_miss++;
            $display("FAIL inval_writes got writes=%0d pending=%0d, required 2 0", n_writes - base_w, exp_wr.size());
        end
        n_vec++;
        if (rd_addr !== 32'd1 || state !== 2'd2 || fifo_q.size() != 0) begin
            n_miss++;
            $display("FAIL inval_wr_ptr got rd_addr=%0d state=%0d fifo_left=%0d, required 1 2 0",
                     rd_addr, state, fifo_q.size());
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 20; i++) push(1'b1, 32'h3000 + 32'(i));
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #2;
            if (state == 2'd3) break;
        end
        n_vec++;
        if (state !== 2'd3) begin
            n_miss++;
            $display("FAIL full_halt got state=%0d, required 3 within budget", state);
        end
        n_vec++;
        if (rd_addr !== 32'd15 || pc_start !== 1'b0 || load_done !== 1'b1) begin
            n_miss++;
            $display("FAIL full_outputs got rd_addr=%0d pc_start=%b load_done=%b, required 15 0 1",
                     rd_addr, pc_start, load_done);
        end
        repeat (5) @(posedge clk);
        #2;
        n_vec++;
        if (fifo_q.size() != 4 || fifo_rd_en !== 1'b0 || state !== 2'd3 || exp_wr.size() != 0) begin
            n_miss++;
            $display("FAIL full_fifo_left got left=%0d rd_en=%b state=%0d pending=%0d, required 4 0 3 0",
                     fifo_q.size(), fifo_rd_en, state, exp_wr.size());
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 8; i++) push(1'b1, 32'h4000 + 32'(i));
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #2;
            if (rd_addr == 32'd7 && state == 2'd2) break;
        end
        n_vec++;
        if (rd_addr !== 32'd7 || bad_redirect !== 1'b0) begin
            n_miss++;
            $display("FAIL rdr_setup got rd_addr=%0d bad=%b, required 7 0", rd_addr, bad_redirect);
        end
        stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'd3;
        @(posedge clk); #2;
        n_vec++;
        if (rd_addr !== 32'd3) begin
            n_miss++;
            $display("FAIL rdr_over_stall got rd_addr=%0d, required 3", rd_addr);
        end
        redirect_valid = 1'b0;
        @(posedge clk); #2;
        n_vec++;
        if (rd_addr !== 32'd3) begin
            n_miss++;
            $display("FAIL rdr_stall_hold got rd_addr=%0d, required 3", rd_addr);
        end
        stall = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'd20;
        @(posedge clk); #2;
        n_vec++;
        if (rd_addr !== 32'd3 || bad_redirect !== 1'b1) begin
            n_miss++;
            $display("FAIL rdr_bad got rd_addr=%0d bad=%b, required 3 1", rd_addr, bad_redirect);
        end
        redirect_valid = 1'b0; mem_stop = 1'b1;
        @(posedge clk); #2;
        n_vec++;
        if (rd_addr !== 32'd3) begin
            n_miss++;
            $display("FAIL rdr_mem_stop got rd_addr=%0d, required 3", rd_addr);
        end
        mem_stop = 1'b0;
        @(posedge clk); #2;
        n_vec++;
        if (rd_addr !== 32'd4 || bad_redirect !== 1'b1 || state !== 2'd2) begin
            n_miss++;
            $display("FAIL rdr_resume got rd_addr=%0d bad=%b state=%0d, required 4 1 2", rd_addr, bad_redirect, state);
        end
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_load_run();
        test_short();
        test_invalid();
        test_full();
        test_redirect();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
